ace_snoop_responder: RTL and testbench
======================================

Name: ace_snoop_responder

Overview:
Cache-side ACE snoop responder: the endpoint that receives AC snoop requests from the CCU snoop interconnect, returns CR responses and, when required, CD data. It looks up the line's coherence state, streams the line out beat by beat, and then commits the resulting state change (make shared, clean or invalidate) back to the cache controller. It sits between one SNOOP_BUS slave port and the private L1 data-cache controller.

Parameters:
AddrWidth, 64, AC address width
DataWidth, 64, CD beat width in bits
LineWidth, 512, cache line width in bits; Beats = LineWidth/DataWidth, must be a power of 2 and at least 1

Ports:
clk_i in 1 clock
rst_i in 1 asynchronous active-high reset
ac_valid_i / ac_ready_o in/out 1 AC handshake
ac_addr_i in AddrWidth snoop address
ac_snoop_i in 4 ACE snoop type
ac_prot_i in 3 protection; captured, otherwise unused
cr_valid_o / cr_ready_i out/in 1 CR handshake
cr_resp_o out 5 {WasUnique, IsShared, PassDirty, Error, DataTransfer}
cd_valid_o / cd_ready_i out/in 1 CD handshake
cd_data_o out DataWidth data beat
cd_last_o out 1 final beat
lu_req_o / lu_gnt_i out/in 1 state lookup request handshake
lu_addr_o out AddrWidth line-aligned lookup address
lu_rvalid_i in 1 lookup result valid, one or more cycles after grant
lu_hit_i, lu_dirty_i, lu_shared_i in 1 each: lookup result, sampled on lu_rvalid_i
rd_req_o / rd_gnt_i out/in 1 beat read handshake
rd_beat_o out log2(Beats) (minimum 1) beat index
rd_rvalid_i in 1 read data valid
rd_data_i in DataWidth read data
upd_valid_o / upd_ready_i out/in 1 state update handshake
upd_addr_o out AddrWidth line address
upd_op_o out 2 update operation: 0=none, 1=make shared, 2=clean, 3=invalidate

Behaviour:
- Reset: FSM goes to IDLE. All valid/req outputs are 0. All data, address and resp registers are 0. ac_ready_o is 0 during reset and 1 in IDLE. Reset mid-transaction aborts the transaction silently.
- One snoop outstanding. ac_ready_o=1 only in IDLE. The AC channel is registered on the handshake.
- FSM states: IDLE, LOOKUP, LU_WAIT, RESP, UPDATE.
  - IDLE to LOOKUP on AC handshake.
  - LOOKUP: lu_req_o held until lu_gnt_i, then LU_WAIT.
  - LU_WAIT: on lu_rvalid_i, compute the response and go to RESP.
  - RESP: done when CR has handshaken and, if DataTransfer=1, the last CD beat has handshaken. Then go to UPDATE if upd_op≠0, else IDLE.
  - UPDATE: upd_valid_o held until upd_ready_i, then IDLE.
- Unsupported snoop types (DVM 1110/1111 and any other encoding outside the list below): skip the lookup, go IDLE→RESP with cr_resp_o=0, no CD, no update.
- Miss: cr_resp_o=0, no CD, upd_op=0.
- Hit, with WasUnique=!shared for every case:
  - ReadOnce (0000): DT=1, IsShared=1, PD=0, upd=none.
  - ReadShared/ReadClean/ReadNotSharedDirty (0001/0010/0011): DT=1, IsShared=1, PD=0, upd=make shared (dirty bit kept).
  - ReadUnique (0111): DT=1, PD=dirty, IsShared=0, upd=invalidate.
  - CleanShared (1000): DT=dirty, PD=dirty, IsShared=1, upd=clean if dirty else none.
  - CleanInvalid (1001): DT=dirty, PD=dirty, IsShared=0, upd=invalidate.
  - MakeInvalid (1101): DT=0, IsShared=0, upd=invalidate.
- Error bit is always 0. lu_addr_o and upd_addr_o are ac_addr with the low log2(LineWidth/8) bits cleared.
- CR: cr_valid_o is asserted on RESP entry. cr_resp_o is stable until the handshake.
- CD stream:
  - One-entry output buffer. rd_req_o for beat k is issued only when the buffer is empty or draining that cycle, with at most one read outstanding.
  - Beats go out in order 0..Beats-1. cd_last_o=1 on beat Beats-1.
  - The beat counter wraps to 0 after the last beat.
  - CD may precede, accompany or follow the CR handshake; the two are independent.
  - cd_data_o and cd_last_o are held stable while cd_valid_o && !cd_ready_i.
- Minimum latency with grant and rvalid arriving as early as possible: AC handshake at cycle 0, lu_req_o at cycle 1, lu_rvalid_i at cycle 2, cr_valid_o at cycle 3, first rd_req_o at cycle 3.
- The update is issued only after the CR and CD handshakes, so the line is never invalidated before its data has been sent.

Test Plan:
- ReadUnique, hit, dirty=1, shared=0, Beats=8, immediate readies → cr_resp_o=5'b10101; 8 CD beats with data equal to the rd_data pattern and cd_last_o on beat 7; then upd_op_o=3 at the line address.
- ReadShared, hit, clean, shared=1 → cr_resp_o=5'b01001; 8 beats; upd_op_o=1.
- CleanShared, hit, clean → cr_resp_o=5'b11000; no CD; no upd_valid_o; ac_ready_o returns high.
- Any snoop that misses → cr_resp_o=0, no CD, no update; DVM 1111 → cr_resp_o=0 with lu_req_o never asserted.
- Randomised cr_ready_i/cd_ready_i stalls of up to 5 cycles → outputs stable under stall, no beat lost or duplicated, ac_ready_o=0 throughout the transaction.
- rst_i asserted during beat 3 of a ReadUnique → all valid/req outputs 0 immediately and no upd_valid_o; after release, ac_ready_o=1 and the next snoop completes correctly.

Source files
------------

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts AC snoops, looks up the line state, returns CR
// and optional CD beats, then commits the resulting coherence update to L1.
module ace_snoop_responder #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineWidth = 512,
  localparam int Beats = LineWidth / DataWidth,
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1,
  localparam int OffW = $clog2(LineWidth / 8)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  input  logic [2:0]           ac_prot_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 lu_req_o,
  input  logic                 lu_gnt_i,
  output logic [AddrWidth-1:0] lu_addr_o,
  input  logic                 lu_rvalid_i,
  input  logic                 lu_hit_i,
  input  logic                 lu_dirty_i,
  input  logic                 lu_shared_i,
  output logic                 rd_req_o,
  input  logic                 rd_gnt_i,
  output logic [BeatW-1:0]     rd_beat_o,
  input  logic                 rd_rvalid_i,
  input  logic [DataWidth-1:0] rd_data_i,
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output logic [AddrWidth-1:0] upd_addr_o,
  output logic [1:0]           upd_op_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_LU_WAIT, S_RESP, S_UPDATE} state_t;

  localparam logic [1:0] OP_NONE   = 2'd0;
  localparam logic [1:0] OP_SHARED = 2'd1;
  localparam logic [1:0] OP_CLEAN  = 2'd2;
  localparam logic [1:0] OP_INV    = 2'd3;

  function automatic logic f_supported(input logic [3:0] snoop);
    case (snoop)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0111, 4'b1000, 4'b1001, 4'b1101: f_supported = 1'b1;
      default:                            f_supported = 1'b0;
    endcase
  endfunction

  // Returns {update op, {WasUnique, IsShared, PassDirty, Error, DataTransfer}}.
  function automatic logic [6:0] f_resp(input logic [3:0] snoop, input logic hit,
                                        input logic dirty, input logic shared);
    logic       wu;
    logic [4:0] r;
    logic [1:0] op;
    wu = ~shared;
    r  = 5'b00000;
    op = OP_NONE;
    if (hit) begin
      case (snoop)
        4'b0000: r = {wu, 1'b1, 1'b0, 1'b0, 1'b1};
        4'b0001, 4'b0010, 4'b0011: begin
          r  = {wu, 1'b1, 1'b0, 1'b0, 1'b1};
          op = OP_SHARED;
        end
        4'b0111: begin
          r  = {wu, 1'b0, dirty, 1'b0, 1'b1};
          op = OP_INV;
        end
        4'b1000: begin
          r  = {wu, 1'b1, dirty, 1'b0, dirty};
          op = dirty ? OP_CLEAN : OP_NONE;
        end
        4'b1001: begin
          r  = {wu, 1'b0, dirty, 1'b0, dirty};
          op = OP_INV;
        end
        4'b1101: begin
          r  = {wu, 1'b0, 1'b0, 1'b0, 1'b0};
          op = OP_INV;
        end
        default: begin
          r  = 5'b00000;
          op = OP_NONE;
        end
      endcase
    end else begin
      r  = 5'b00000;
      op = OP_NONE;
    end
    f_resp = {op, r};
  endfunction

  state_t               r_state;
  logic [AddrWidth-1:0] r_addr;
  logic [3:0]           r_snoop;
  logic [2:0]           r_unused_prot;
  logic                 r_cr_done;
  logic                 r_cd_done;
  logic                 r_rd_out;
  logic                 r_rd_all;
  logic [BeatW-1:0]     r_ld_beat;

  logic       w_cr_hs;
  logic       w_cd_hs;
  logic       w_buf_free;
  logic       w_cr_ok;
  logic       w_cd_ok;
  logic [6:0] w_lu_res;
  logic       w_unused;

  assign w_cr_hs    = cr_valid_o & cr_ready_i;
  assign w_cd_hs    = cd_valid_o & cd_ready_i;
  assign w_buf_free = ~cd_valid_o | cd_ready_i;
  assign w_cr_ok    = r_cr_done | w_cr_hs;
  assign w_cd_ok    = ~cr_resp_o[0] | r_cd_done | (w_cd_hs & cd_last_o);
  assign w_lu_res   = f_resp(r_snoop, lu_hit_i, lu_dirty_i, lu_shared_i);
  assign w_unused   = ^ac_addr_i[OffW-1:0];
  assign lu_addr_o  = r_addr;
  assign upd_addr_o = r_addr;

  // Snoop FSM, CD read sequencer, one-entry CD buffer and all registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_snoop       <= 4'd0;
      r_unused_prot <= 3'd0;
      r_cr_done     <= 1'b0;
      r_cd_done     <= 1'b0;
      r_rd_out      <= 1'b0;
      r_rd_all      <= 1'b0;
      r_ld_beat     <= '0;
      ac_ready_o    <= 1'b0;
      cr_valid_o    <= 1'b0;
      cr_resp_o     <= 5'd0;
      cd_valid_o    <= 1'b0;
      cd_data_o     <= '0;
      cd_last_o     <= 1'b0;
      lu_req_o      <= 1'b0;
      rd_req_o      <= 1'b0;
      rd_beat_o     <= '0;
      upd_valid_o   <= 1'b0;
      upd_op_o      <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ac_valid_i && ac_ready_o) begin
            ac_ready_o    <= 1'b0;
            r_addr        <= {ac_addr_i[AddrWidth-1:OffW], {OffW{1'b0}}};
            r_snoop       <= ac_snoop_i;
            r_unused_prot <= ac_prot_i;
            if (f_supported(ac_snoop_i)) begin
              r_state  <= S_LOOKUP;
              lu_req_o <= 1'b1;
            end else begin
              r_state    <= S_RESP;
              cr_valid_o <= 1'b1;
              cr_resp_o  <= 5'd0;
              upd_op_o   <= OP_NONE;
              r_rd_all   <= 1'b1;
            end
          end else begin
            ac_ready_o <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (lu_gnt_i) begin
            lu_req_o <= 1'b0;
            r_state  <= S_LU_WAIT;
          end
        end
        S_LU_WAIT: begin
          if (lu_rvalid_i) begin
            {upd_op_o, cr_resp_o} <= w_lu_res;
            cr_valid_o <= 1'b1;
            rd_req_o   <= w_lu_res[0];
            rd_beat_o  <= '0;
            r_ld_beat  <= '0;
            r_rd_all   <= ~w_lu_res[0];
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_cr_hs) begin
            cr_valid_o <= 1'b0;
            r_cr_done  <= 1'b1;
          end
          // Next read only once the buffer is free and nothing is in flight.
          if (rd_req_o) begin
            if (rd_gnt_i) begin
              rd_req_o <= 1'b0;
              r_rd_out <= 1'b1;
              if (rd_beat_o == BeatW'(Beats - 1)) begin
                r_rd_all  <= 1'b1;
                rd_beat_o <= '0;
              end else begin
                rd_beat_o <= rd_beat_o + BeatW'(1);
              end
            end
          end else if (!r_rd_out && !r_rd_all && w_buf_free) begin
            rd_req_o <= 1'b1;
          end
          if (rd_rvalid_i) begin
            cd_valid_o <= 1'b1;
            cd_data_o  <= rd_data_i;
            cd_last_o  <= (r_ld_beat == BeatW'(Beats - 1));
            r_ld_beat  <= (r_ld_beat == BeatW'(Beats - 1)) ? '0 : r_ld_beat + BeatW'(1);
            r_rd_out   <= 1'b0;
          end else if (w_cd_hs) begin
            cd_valid_o <= 1'b0;
          end
          if (w_cd_hs && cd_last_o) begin
            r_cd_done <= 1'b1;
          end
          if (w_cr_ok && w_cd_ok) begin
            r_cr_done <= 1'b0;
            r_cd_done <= 1'b0;
            if (upd_op_o != OP_NONE) begin
              r_state     <= S_UPDATE;
              upd_valid_o <= 1'b1;
            end else begin
              r_state    <= S_IDLE;
              ac_ready_o <= 1'b1;
            end
          end
        end
        S_UPDATE: begin
          if (upd_ready_i) begin
            upd_valid_o <= 1'b0;
            ac_ready_o  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: a reactive cache-side model drives
// grants/data while every observed handshake is checked against hand values.
module tb_ace_snoop_responder;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 512;
  localparam int BEATS = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ac_valid_i, ac_ready_o;
  logic [AW-1:0] ac_addr_i;
  logic [3:0]    ac_snoop_i;
  logic [2:0]    ac_prot_i;
  logic          cr_valid_o, cr_ready_i;
  logic [4:0]    cr_resp_o;
  logic          cd_valid_o, cd_ready_i;
  logic [DW-1:0] cd_data_o;
  logic          cd_last_o;
  logic          lu_req_o, lu_gnt_i;
  logic [AW-1:0] lu_addr_o;
  logic          lu_rvalid_i, lu_hit_i, lu_dirty_i, lu_shared_i;
  logic          rd_req_o, rd_gnt_i;
  logic [2:0]    rd_beat_o;
  logic          rd_rvalid_i;
  logic [DW-1:0] rd_data_i;
  logic          upd_valid_o, upd_ready_i;
  logic [AW-1:0] upd_addr_o;
  logic [1:0]    upd_op_o;

  always #5 clk_i = ~clk_i;

  ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
    .cd_last_o(cd_last_o),
    .lu_req_o(lu_req_o), .lu_gnt_i(lu_gnt_i), .lu_addr_o(lu_addr_o),
    .lu_rvalid_i(lu_rvalid_i), .lu_hit_i(lu_hit_i), .lu_dirty_i(lu_dirty_i),
    .lu_shared_i(lu_shared_i),
    .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_beat_o(rd_beat_o),
    .rd_rvalid_i(rd_rvalid_i), .rd_data_i(rd_data_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
    .upd_addr_o(upd_addr_o), .upd_op_o(upd_op_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tag = 0, cyc = 0;
  int ncr, nbeats, nupd;
  int t_ac, t_lu, t_cr, t_rd;
  bit busy = 1'b0, stall_mode = 1'b0, lu_seen;
  logic m_hit, m_dirty, m_shared;
  logic [4:0]    got_resp;
  logic [1:0]    got_op;
  logic [AW-1:0] got_upd_addr, lu_addr_seen;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int t, input int b);
    return {16'(t) ^ 16'hC0DE, 40'h12_3456_789A, 8'(b)};
  endfunction

  function automatic bit done_f(input int eb, input logic [1:0] eo);
    if (eo != 2'd0) return nupd >= 1;
    return (ncr >= 1) && (nbeats >= eb);
  endfunction

  // One clock: log handshakes seen before the edge, then react after it.
  task automatic step();
    logic hs_ac, hs_lu, hs_rd, hs_cr, hs_cd, hs_upd;
    logic p_cdv, p_cdr, p_cdl, p_crv, p_crr;
    logic [63:0] p_cdd;
    logic [4:0]  p_resp;
    logic [2:0]  p_beat;
    hs_ac  = ac_valid_i & ac_ready_o;
    hs_lu  = lu_req_o & lu_gnt_i;
    hs_rd  = rd_req_o & rd_gnt_i;
    hs_cr  = cr_valid_o & cr_ready_i;
    hs_cd  = cd_valid_o & cd_ready_i;
    hs_upd = upd_valid_o & upd_ready_i;
    p_cdv = cd_valid_o; p_cdr = cd_ready_i; p_cdd = cd_data_o; p_cdl = cd_last_o;
    p_crv = cr_valid_o; p_crr = cr_ready_i; p_resp = cr_resp_o; p_beat = rd_beat_o;
    if (busy && stall_mode) check("ac_ready_busy", ac_ready_o, 1'b0);
    if (hs_cd) begin
      check("cd_data", cd_data_o, pat(tag, nbeats));
      check("cd_last", cd_last_o, (nbeats == BEATS - 1) ? 1 : 0);
      nbeats++;
    end
    if (hs_cr) begin ncr++; got_resp = cr_resp_o; end
    if (hs_upd) begin nupd++; got_op = upd_op_o; got_upd_addr = upd_addr_o; end
    @(posedge clk_i); #1;
    cyc++;
    if (hs_ac) begin ac_valid_i = 1'b0; busy = 1'b1; t_ac = cyc - 1; end
    if (p_cdv && !p_cdr) begin
      check("cd_stall_valid", cd_valid_o, 1'b1);
      check("cd_stall_data", cd_data_o, p_cdd);
      check("cd_stall_last", cd_last_o, p_cdl);
    end
    if (p_crv && !p_crr) begin
      check("cr_stall_valid", cr_valid_o, 1'b1);
      check("cr_stall_resp", cr_resp_o, p_resp);
    end
    if (lu_req_o) begin
      lu_seen = 1'b1;
      lu_addr_seen = lu_addr_o;
      if (t_lu < 0) t_lu = cyc;
    end
    if (cr_valid_o && t_cr < 0) t_cr = cyc;
    if (rd_req_o && t_rd < 0) t_rd = cyc;
    lu_gnt_i    = lu_req_o;
    lu_rvalid_i = hs_lu;
    lu_hit_i    = m_hit;
    lu_dirty_i  = m_dirty;
    lu_shared_i = m_shared;
    rd_gnt_i    = rd_req_o;
    rd_rvalid_i = hs_rd;
    rd_data_i   = hs_rd ? pat(tag, int'(p_beat)) : 64'd0;
    cr_ready_i  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    cd_ready_i  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    upd_ready_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_snoop(input string name, input logic [63:0] addr, input logic [3:0] snp,
                           input logic h, input logic d, input logic s,
                           input logic [4:0] exp_resp, input int exp_beats,
                           input logic [1:0] exp_op, input bit stall, input int abort_at);
    int budget;
    tag++;
    m_hit = h; m_dirty = d; m_shared = s; stall_mode = stall;
    ncr = 0; nbeats = 0; nupd = 0; lu_seen = 1'b0;
    t_ac = -1; t_lu = -1; t_cr = -1; t_rd = -1;
    ac_valid_i = 1'b1; ac_addr_i = addr; ac_snoop_i = snp; ac_prot_i = 3'b010;
    budget = 0;
    while (!busy && budget < 20) begin step(); budget++; end
    check({name, "_ac_hs"}, busy, 1'b1);
    budget = 0;
    while (!done_f(exp_beats, exp_op) && !(abort_at >= 0 && nbeats == abort_at) && budget < 400) begin
      step();
      budget++;
    end
    if (abort_at >= 0) begin
      check({name, "_abort_point"}, nbeats, abort_at);
      return;
    end
    check({name, "_timeout"}, (budget < 400) ? 1 : 0, 1);
    busy = 1'b0;
    stall_mode = 1'b0;
    check({name, "_ac_ready_back"}, ac_ready_o, 1'b1);
    step(); step();
    check({name, "_cr_count"}, ncr, 1);
    check({name, "_cr_resp"}, got_resp, exp_resp);
    check({name, "_cd_beats"}, nbeats, exp_beats);
    check({name, "_upd_count"}, nupd, (exp_op != 2'd0) ? 1 : 0);
    if (exp_op != 2'd0) begin
      check({name, "_upd_op"}, got_op, exp_op);
      check({name, "_upd_addr"}, got_upd_addr, addr & ~64'h3F);
    end
    if (lu_seen) check({name, "_lu_addr"}, lu_addr_seen, addr & ~64'h3F);
  endtask

  initial begin
    rst_i = 1'b1;
    ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = 4'd0; ac_prot_i = 3'd0;
    cr_ready_i = 1'b0; cd_ready_i = 1'b0; lu_gnt_i = 1'b0; lu_rvalid_i = 1'b0;
    lu_hit_i = 1'b0; lu_dirty_i = 1'b0; lu_shared_i = 1'b0;
    rd_gnt_i = 1'b0; rd_rvalid_i = 1'b0; rd_data_i = '0; upd_ready_i = 1'b0;
    m_hit = 1'b0; m_dirty = 1'b0; m_shared = 1'b0;
    #12;
    check("rst_ac_ready", ac_ready_o, 1'b0);
    check("rst_cr_valid", cr_valid_o, 1'b0);
    check("rst_cd_valid", cd_valid_o, 1'b0);
    check("rst_lu_req", lu_req_o, 1'b0);
    check("rst_rd_req", rd_req_o, 1'b0);
    check("rst_upd_valid", upd_valid_o, 1'b0);
    check("rst_cr_resp", cr_resp_o, 5'd0);
    check("rst_cd_data", cd_data_o, 64'd0);
    check("rst_upd_op", upd_op_o, 2'd0);
    check("rst_lu_addr", lu_addr_o, 64'd0);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("idle_ac_ready", ac_ready_o, 1'b1);

    run_snoop("rdunique", 64'h1234_5678_9ABC_DEF7, 4'b0111, 1'b1, 1'b1, 1'b0, 5'b10101, 8, 2'd3, 1'b0, -1);
    check("lat_lu_req", t_lu - t_ac, 1);
    check("lat_cr_valid", t_cr - t_ac, 3);
    check("lat_rd_req", t_rd - t_ac, 3);
    run_snoop("rdshared", 64'h0000_0000_8000_1040, 4'b0001, 1'b1, 1'b0, 1'b1, 5'b01001, 8, 2'd1, 1'b0, -1);
    run_snoop("clnshared_clean", 64'h0000_0000_0000_2A7F, 4'b1000, 1'b1, 1'b0, 1'b0, 5'b11000, 0, 2'd0, 1'b0, -1);
    run_snoop("clnshared_dirty", 64'h0000_00FF_0000_3001, 4'b1000, 1'b1, 1'b1, 1'b1, 5'b01101, 8, 2'd2, 1'b0, -1);
    run_snoop("mkinvalid", 64'hFFFF_FFFF_FFFF_FFFF, 4'b1101, 1'b1, 1'b1, 1'b0, 5'b10000, 0, 2'd3, 1'b0, -1);
    run_snoop("miss", 64'h0000_0000_0000_4400, 4'b0111, 1'b0, 1'b1, 1'b0, 5'b00000, 0, 2'd0, 1'b0, -1);
    run_snoop("dvm", 64'h0000_0000_0000_5500, 4'b1111, 1'b1, 1'b1, 1'b0, 5'b00000, 0, 2'd0, 1'b0, -1);
    check("dvm_no_lookup", lu_seen, 1'b0);
    run_snoop("stall_clninv", 64'h0000_0000_0000_6680, 4'b1001, 1'b1, 1'b1, 1'b1, 5'b00101, 8, 2'd3, 1'b1, -1);
    run_snoop("stall_rdonce", 64'h0000_0000_0000_77C0, 4'b0000, 1'b1, 1'b1, 1'b0, 5'b11001, 8, 2'd0, 1'b1, -1);

    run_snoop("rst_rdunique", 64'h0000_0000_0000_8800, 4'b0111, 1'b1, 1'b1, 1'b0, 5'b10101, 8, 2'd3, 1'b0, 3);
    #2; rst_i = 1'b1; #1;
    check("midrst_cr_valid", cr_valid_o, 1'b0);
    check("midrst_cd_valid", cd_valid_o, 1'b0);
    check("midrst_lu_req", lu_req_o, 1'b0);
    check("midrst_rd_req", rd_req_o, 1'b0);
    check("midrst_upd_valid", upd_valid_o, 1'b0);
    check("midrst_ac_ready", ac_ready_o, 1'b0);
    busy = 1'b0; ac_valid_i = 1'b0; lu_gnt_i = 1'b0; lu_rvalid_i = 1'b0;
    rd_gnt_i = 1'b0; rd_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    nupd = 0;
    step(); step(); step();
    check("postrst_no_upd", nupd, 0);
    check("postrst_ac_ready", ac_ready_o, 1'b1);
    run_snoop("postrst_rdnsd", 64'h0000_0000_0000_99A5, 4'b0011, 1'b1, 1'b1, 1'b0, 5'b11001, 8, 2'd1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
